// File: rtl/hlsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hlsm_pkg
//  Description : Shared types and constants for the resource-constrained
//                HLSM controller computing k=(a*b+c*d)/e and l=f/g.
//                Holds the controller state encoding, the default data
//                width and the derived divider / run latencies.
//  Revision    : 1.0  initial release
// ============================================================================
package hlsm_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Divider result appears this many cycles after its start cycle.
    localparam int DIV_LAT = DEFAULT_WIDTH;

    // Cycles from the accepting edge to the Done cycle (inclusive).
    localparam int RUN_LAT = 4 + 2 * (DEFAULT_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL1  = 3'd1,
        MUL2  = 3'd2,
        ADD   = 3'd3,
        DIV_K = 3'd4,
        DIV_L = 3'd5,
        FIN   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hlsm_shared_fu_sched_seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div
//  Description : Radix-2 restoring signed divider, truncating toward zero.
//                One quotient bit per cycle on operand magnitudes; the sign
//                is applied when the result is registered.
//  Ports       : Clk, Rst        clock, synchronous active-high reset
//                start           begin a division (ignored while busy)
//                dividend        signed dividend, sampled with start
//                divisor         signed divisor, sampled with start
//                quotient        signed quotient, held until next result
//                valid           1-cycle pulse, WIDTH cycles after start
//                dz              divisor was zero (quotient forced to 0)
//  Revision    : 1.0  initial release
// ============================================================================
module seq_div
    import hlsm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             valid,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] qsh_q;
    logic [WIDTH-1:0] dv_q;
    logic             neg_q;
    logic             zero_q;
    logic [WIDTH-1:0] quotient_q;
    logic             valid_q;
    logic             dz_q;

    logic [WIDTH-1:0] dd_abs;
    logic [WIDTH-1:0] dv_abs;
    logic [WIDTH-1:0] rem_in;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] dv_in;
    logic [WIDTH:0]   shift;
    logic             ge;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] q_n;

    // Magnitudes as unsigned: the most-negative value maps to 2^(WIDTH-1),
    // which still fits, so most-negative / -1 wraps back to most-negative.
    assign dd_abs = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign dv_abs = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

    // One restoring step. On the start cycle the first step is taken
    // directly from the fresh operands so that WIDTH steps complete in
    // time for valid to rise WIDTH cycles after the start cycle.
    always_comb begin
        rem_in = busy_q ? rem_q : '0;
        q_in   = busy_q ? qsh_q : dd_abs;
        dv_in  = busy_q ? dv_q  : dv_abs;
        shift  = {rem_in, q_in[WIDTH-1]};
        ge     = (shift >= {1'b0, dv_in});
        rem_n  = ge ? (shift - {1'b0, dv_in}) : shift;
        q_n    = {q_in[WIDTH-2:0], ge};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            qsh_q      <= '0;
            dv_q       <= '0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            quotient_q <= '0;
            valid_q    <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (busy_q) begin
                rem_q <= rem_n[WIDTH-1:0];
                qsh_q <= q_n;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    busy_q     <= 1'b0;
                    valid_q    <= 1'b1;
                    dz_q       <= zero_q;
                    quotient_q <= zero_q ? '0 : (neg_q ? (~q_n + 1'b1) : q_n);
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(1);
                rem_q  <= rem_n[WIDTH-1:0];
                qsh_q  <= q_n;
                dv_q   <= dv_abs;
                neg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                zero_q <= (divisor == '0);
            end
        end
    end

    assign quotient = quotient_q;
    assign valid    = valid_q;
    assign dz       = dz_q;

endmodule
`default_nettype wire

// File: rtl/hlsm_shared_fu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hlsm_shared_fu_sched
//  Description : Resource-constrained HLSM controller computing
//                k = (a*b + c*d)/e and l = f/g on one shared multiplier,
//                one adder and one shared iterative signed divider.
//  Ports       : Clk, Rst        clock, synchronous active-high reset
//                Start           run request, honoured only in IDLE
//                a..g            signed operands, captured on accepted Start
//                k, l            registered signed results
//                Done            registered 1-cycle completion pulse
//                Busy            high whenever the FSM is not in IDLE
//                div_by_zero     sticky per run: e==0 or g==0 seen
//  Revision    : 1.0  initial release
// ============================================================================
module hlsm_shared_fu_sched
    import hlsm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] c,
    input  logic signed [WIDTH-1:0] d,
    input  logic signed [WIDTH-1:0] e,
    input  logic signed [WIDTH-1:0] f,
    input  logic signed [WIDTH-1:0] g,
    output logic signed [WIDTH-1:0] k,
    output logic signed [WIDTH-1:0] l,
    output logic                    Done,
    output logic                    Busy,
    output logic                    div_by_zero
);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q;
    logic [WIDTH-1:0] h_q, i_q, j_q;
    logic [WIDTH-1:0] k_q, l_q;
    logic             done_q;
    logic             dz_q;
    logic             div_start_q;

    logic [WIDTH-1:0] mul_x, mul_y, prod, sum;
    logic [WIDTH-1:0] div_dd, div_dv, div_quot;
    logic             div_valid, div_dz;

    // Shared multiplier: a*b in MUL1, c*d otherwise. Only the low WIDTH
    // bits are kept, which are the same for signed and unsigned operands.
    assign mul_x = (state_q == MUL1) ? a_q : c_q;
    assign mul_y = (state_q == MUL1) ? b_q : d_q;
    assign prod  = mul_x * mul_y;
    assign sum   = h_q + i_q;

    // Shared divider: j/e during DIV_K, f/g during DIV_L.
    assign div_dd = (state_q == DIV_L) ? f_q : j_q;
    assign div_dv = (state_q == DIV_L) ? g_q : e_q;

    seq_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (div_start_q),
        .dividend (div_dd),
        .divisor  (div_dv),
        .quotient (div_quot),
        .valid    (div_valid),
        .dz       (div_dz)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            e_q         <= '0;
            f_q         <= '0;
            g_q         <= '0;
            h_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            l_q         <= '0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            div_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= c;
                        d_q     <= d;
                        e_q     <= e;
                        f_q     <= f;
                        g_q     <= g;
                        dz_q    <= 1'b0;
                        state_q <= MUL1;
                    end
                end
                MUL1: begin
                    h_q     <= prod;
                    state_q <= MUL2;
                end
                MUL2: begin
                    i_q     <= prod;
                    state_q <= ADD;
                end
                ADD: begin
                    j_q         <= sum;
                    // Divider start is registered so it is high during the
                    // first DIV_K cycle, when j is already stable.
                    div_start_q <= 1'b1;
                    state_q     <= DIV_K;
                end
                DIV_K: begin
                    if (div_valid) begin
                        k_q         <= div_quot;
                        dz_q        <= dz_q | div_dz;
                        div_start_q <= 1'b1;
                        state_q     <= DIV_L;
                    end
                end
                DIV_L: begin
                    if (div_valid) begin
                        l_q     <= div_quot;
                        dz_q    <= dz_q | div_dz;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign k           = k_q;
    assign l           = l_q;
    assign Done        = done_q;
    assign Busy        = (state_q != IDLE);
    assign div_by_zero = dz_q;

endmodule
`default_nettype wire
